// File: rtl/vga_mode_sequencer_if.sv
// Control/status bundle between the mode register, the VGA converter and the sequencer.
interface vga_mode_sequencer_if;
  logic mode_req;   // requested mode: 1 = YPbPr, 0 = RGB
  logic vsync;      // converter vsync, active high
  logic ypbpr_en;   // applied mode
  logic blank;      // force output black
  logic busy;       // switch or recovery in progress
  logic sync_lost;  // vsync missing for the timeout window

  modport master (
    output mode_req, vsync,
    input  ypbpr_en, blank, busy, sync_lost
  );

  modport slave (
    input  mode_req, vsync,
    output ypbpr_en, blank, busy, sync_lost
  );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Frame-aligned RGB/YPbPr mode sequencer: mutes MUTE_FRAMES frames around every
// mode switch and blanks while vsync is missing.
module vga_mode_sequencer #(
  parameter int unsigned MUTE_FRAMES = 2,
  parameter int unsigned VS_TIMEOUT  = 2000000,
  parameter int unsigned CNT_W       = 22
) (
  input  logic               clk,
  input  logic               reset_n,
  vga_mode_sequencer_if.slave bus
);

  localparam int unsigned FCNT_W = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(MUTE_FRAMES - 1);
  localparam logic [CNT_W-1:0]  TCNT_LAST = CNT_W'(VS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  TCNT_MAX  = '1;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_PRE,
    ST_SWITCH,
    ST_POST,
    ST_NOSYNC
  } state_t;

  state_t            state;
  logic [FCNT_W-1:0] fcnt;
  logic [CNT_W-1:0]  tcnt;
  logic              vsync_q;
  logic              target;
  logic              ypbpr_en_q;
  logic              blank_q;
  logic              busy_q;
  logic              sync_lost_q;
  logic              vs_rise;
  logic              timeout;

  assign vs_rise = bus.vsync & ~vsync_q;
  // A vsync edge landing on the last timeout cycle keeps sync alive.
  assign timeout = (tcnt == TCNT_LAST) & ~vs_rise;

  assign bus.ypbpr_en  = ypbpr_en_q;
  assign bus.blank     = blank_q;
  assign bus.busy      = busy_q;
  assign bus.sync_lost = sync_lost_q;

  // vsync edge detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= bus.vsync;
    end
  end

  // Cycles since the last vsync rising edge, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (vs_rise) begin
      tcnt <= '0;
    end else if (tcnt != TCNT_MAX) begin
      tcnt <= tcnt + CNT_W'(1);
    end
  end

  // Mode sequencing FSM with registered outputs; sync loss overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_POST;
      fcnt        <= '0;
      target      <= 1'b0;
      ypbpr_en_q  <= 1'b0;
      blank_q     <= 1'b1;
      busy_q      <= 1'b1;
      sync_lost_q <= 1'b0;
    end else if (timeout) begin
      // Already blanked in NOSYNC, so the applied mode may keep following the request.
      if (state == ST_NOSYNC) begin
        ypbpr_en_q <= bus.mode_req;
      end
      state       <= ST_NOSYNC;
      fcnt        <= '0;
      blank_q     <= 1'b1;
      busy_q      <= 1'b1;
      sync_lost_q <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.mode_req != ypbpr_en_q) begin
            state   <= ST_PRE;
            target  <= bus.mode_req;
            fcnt    <= '0;
            blank_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_PRE: begin
          if (vs_rise) begin
            if (fcnt == FCNT_LAST) begin
              state <= ST_SWITCH;
              fcnt  <= '0;
            end else begin
              fcnt <= fcnt + FCNT_W'(1);
            end
          end
        end
        ST_SWITCH: begin
          ypbpr_en_q <= target;
          state      <= ST_POST;
          fcnt       <= '0;
        end
        ST_POST: begin
          if (vs_rise) begin
            if (fcnt == FCNT_LAST) begin
              state   <= ST_RUN;
              fcnt    <= '0;
              blank_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              fcnt <= fcnt + FCNT_W'(1);
            end
          end
        end
        ST_NOSYNC: begin
          ypbpr_en_q <= bus.mode_req;
          if (vs_rise) begin
            state       <= ST_POST;
            fcnt        <= '0;
            sync_lost_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_POST;
          fcnt    <= '0;
          blank_q <= 1'b1;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer: vector table, directed corner cases,
// and randomized vsync/mode traffic against a frame-level reference model.
module tb_vga_mode_sequencer;

  localparam int MF  = 2;
  localparam int TO  = 50;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  localparam int PH_RUN    = 0;
  localparam int PH_PRE    = 1;
  localparam int PH_SWITCH = 2;
  localparam int PH_POST   = 3;
  localparam int PH_NOSYNC = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  vga_mode_sequencer_if bus();

  vga_mode_sequencer #(
    .MUTE_FRAMES(MF),
    .VS_TIMEOUT (TO),
    .CNT_W      (CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase, frames seen in the current mute window, idle cycles.
  int m_phase;
  int m_frames;
  int m_idle;
  bit m_vs_prev;
  bit m_applied;
  bit m_target;

  bit prev_yp;
  bit prev_blank;

  typedef struct {
    bit         mode;
    bit         vs;
    logic [3:0] exp;   // {ypbpr_en, blank, busy, sync_lost}
  } vec_t;

  vec_t tbl[17];

  function automatic logic [3:0] dut_out();
    return {bus.ypbpr_en, bus.blank, bus.busy, bus.sync_lost};
  endfunction

  function automatic logic [3:0] model_out();
    bit muted;
    muted = (m_phase != PH_RUN);
    return {m_applied, muted, muted, m_phase == PH_NOSYNC};
  endfunction

  function automatic void check(string name, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {yp,blank,busy,lost}=%b expected %b at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_phase   = PH_POST;
    m_frames  = 0;
    m_idle    = 0;
    m_vs_prev = 1'b0;
    m_applied = 1'b0;
    m_target  = 1'b0;
  endfunction

  // One clock of the model, using the inputs present at that clock edge.
  function automatic void model_step(bit m, bit v);
    bit rise;
    bit lost;
    rise = v && !m_vs_prev;
    lost = !rise && (m_idle == TO - 1);
    m_vs_prev = v;
    if (rise) m_idle = 0;
    else if (m_idle < SAT) m_idle = m_idle + 1;

    if (lost) begin
      if (m_phase == PH_NOSYNC) m_applied = m;
      m_phase = PH_NOSYNC;
    end else begin
      case (m_phase)
        PH_RUN: if (m != m_applied) begin
          m_target = m;
          m_frames = 0;
          m_phase  = PH_PRE;
        end
        PH_PRE: if (rise) begin
          m_frames++;
          if (m_frames == MF) m_phase = PH_SWITCH;
        end
        PH_SWITCH: begin
          m_applied = m_target;
          m_frames  = 0;
          m_phase   = PH_POST;
        end
        PH_POST: if (rise) begin
          m_frames++;
          if (m_frames == MF) m_phase = PH_RUN;
        end
        default: begin
          m_applied = m;
          if (rise) begin
            m_frames = 0;
            m_phase  = PH_POST;
          end
        end
      endcase
    end
  endfunction

  // Drive one cycle, then compare against the model and the blank/mode invariant.
  task automatic step(input bit m, input bit v);
    bus.mode_req = m;
    bus.vsync    = v;
    @(posedge clk);
    model_step(m, v);
    #1;
    check("model", dut_out(), model_out());
    if (bus.ypbpr_en !== prev_yp) begin
      n_cmp++;
      if (!(bus.blank === 1'b1 && prev_blank)) begin
        n_bad++;
        $display("FAIL invariant: ypbpr_en changed to %b with blank %b (previous blank %b) at t=%0t",
                 bus.ypbpr_en, bus.blank, prev_blank, $time);
      end
    end
    prev_yp    = bus.ypbpr_en;
    prev_blank = bus.blank;
  endtask

  task automatic frame(input bit m, input int period);
    for (int i = 0; i < period; i++) step(m, i < 3);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.mode_req = 1'b0;
    bus.vsync    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    prev_yp    = 1'b0;
    prev_blank = 1'b1;
    #1;
    check("reset", dut_out(), 4'b0110);
  endtask

  // Assert reset between clock edges and require reset values without a clock.
  task automatic reset_mid(input string name);
    #3;
    reset_n = 1'b0;
    #1;
    check(name, dut_out(), 4'b0110);
    bus.mode_req = 1'b0;
    bus.vsync    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    prev_yp    = 1'b0;
    prev_blank = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int period;
    int pos;
    bit mode;

    // Startup, RGB->YPbPr switch ignoring a request change in PRE, then re-entry back to RGB.
    tbl[0]  = '{0, 0, 4'b0110};
    tbl[1]  = '{0, 1, 4'b0110};
    tbl[2]  = '{0, 0, 4'b0110};
    tbl[3]  = '{0, 1, 4'b0000};
    tbl[4]  = '{1, 0, 4'b0110};
    tbl[5]  = '{0, 1, 4'b0110};
    tbl[6]  = '{0, 0, 4'b0110};
    tbl[7]  = '{0, 1, 4'b0110};
    tbl[8]  = '{0, 0, 4'b1110};
    tbl[9]  = '{0, 1, 4'b1110};
    tbl[10] = '{0, 0, 4'b1110};
    tbl[11] = '{0, 1, 4'b1000};
    tbl[12] = '{0, 0, 4'b1110};
    tbl[13] = '{0, 1, 4'b1110};
    tbl[14] = '{0, 0, 4'b1110};
    tbl[15] = '{0, 1, 4'b1110};
    tbl[16] = '{0, 0, 4'b0110};

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].mode, tbl[i].vs);
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Sync loss in RUN, mode follows request in NOSYNC, recovery through POST.
    do_reset();
    repeat (3) frame(0, 20);
    check("run_before_loss", dut_out(), 4'b0000);
    repeat (30) step(0, 0);
    check("pre_timeout", dut_out(), 4'b0000);
    step(0, 0);
    check("timeout", dut_out(), 4'b0111);
    step(1, 0);
    check("nosync_track", dut_out(), 4'b1111);
    step(1, 1);
    check("nosync_exit", dut_out(), 4'b1110);
    for (int i = 0; i < 19; i++) step(1, i < 2);
    frame(1, 20);
    check("post_one_frame", dut_out(), 4'b1110);
    frame(1, 20);
    check("post_done", dut_out(), 4'b1000);
    step(1, 0);
    reset_mid("async_reset_run");

    // vsync edge exactly on the last timeout cycle keeps sync; one cycle later loses it.
    do_reset();
    repeat (3) frame(0, 20);
    repeat (3) frame(0, 50);
    check("edge_on_timeout", dut_out(), 4'b0000);
    frame(0, 51);
    check("timeout_51", dut_out(), 4'b0111);

    // Reset in PRE after one muted frame: no partial progress survives.
    do_reset();
    repeat (2) frame(0, 20);
    check("run_reached", dut_out(), 4'b0000);
    step(1, 0);
    check("pre_entry", dut_out(), 4'b0110);
    frame(1, 20);
    step(1, 0);
    reset_mid("async_reset_pre");
    frame(1, 20);
    check("post_restart", dut_out(), 4'b0110);

    // Random vsync periods (some past the timeout) with sporadic mode requests.
    do_reset();
    mode   = 1'b0;
    period = 20;
    pos    = 0;
    for (int c = 0; c < 4000; c++) begin
      if (pos == period) begin
        pos    = 0;
        period = $urandom_range(10, 60);
      end
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      step(mode, pos < 3);
      pos++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
